// File: rtl/irq_pending_capture_if.sv
// irq_pending_capture_if
// Groups the request, mask, acknowledge and encoder-facing signals of the
// irq_pending_capture stage so that they can be passed around as one bundle.
//   req_in   [3:0] raw asynchronous requests, bit k is channel k
//   mask     [3:0] per-channel presentation enable
//   ack            single-cycle acknowledge strobe
//   ack_id   [1:0] channel being acknowledged
//   ovf_clr        clears all overflow flags
//   i0..i3         masked pending bits towards the priority encoder
//   irq            OR of i0..i3
//   pending  [3:0] raw pending flops
//   ovf      [3:0] sticky per-channel overflow flags
// master: the side that drives requests and consumes the encoder inputs.
// slave : the capture stage itself.
interface irq_pending_capture_if;
  logic [3:0] req_in;
  logic [3:0] mask;
  logic       ack;
  logic [1:0] ack_id;
  logic       ovf_clr;
  logic       i0;
  logic       i1;
  logic       i2;
  logic       i3;
  logic       irq;
  logic [3:0] pending;
  logic [3:0] ovf;

  modport master (
    output req_in, mask, ack, ack_id, ovf_clr,
    input  i0, i1, i2, i3, irq, pending, ovf
  );

  modport slave (
    input  req_in, mask, ack, ack_id, ovf_clr,
    output i0, i1, i2, i3, irq, pending, ovf
  );
endinterface

// File: rtl/irq_pending_capture.sv
// irq_pending_capture
// Four-channel request capture stage feeding a 4-input priority encoder.
// Each raw request is synchronised through SYNC_STAGES flops, turned into an
// event (rising edge in edge mode, level in level mode) and held in a pending
// flop until the consumer acknowledges that channel. A new event on a channel
// whose previous event is still pending raises a sticky overflow flag.
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset, clears every flop
//   bus    irq_pending_capture_if.slave (see interface header for signals)
// Parameters:
//   SYNC_STAGES  synchroniser depth, 2..4
//   EDGE_MODE    1 = rising-edge sticky capture, 0 = pending follows level
module irq_pending_capture #(
  parameter int SYNC_STAGES = 2,
  parameter bit EDGE_MODE   = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  irq_pending_capture_if.slave        bus
);

  logic [3:0] sync_q [SYNC_STAGES];
  logic [3:0] dly_q;
  logic [3:0] pending_q;
  logic [3:0] ovf_q;

  logic [3:0] sync_s;
  logic [3:0] rise;
  logic [3:0] ack_hit;
  logic [3:0] ovf_set;
  logic [3:0] pending_nxt;
  logic [3:0] ovf_nxt;
  logic [3:0] presented;

  assign sync_s = sync_q[SYNC_STAGES-1];
  assign rise   = sync_s & ~dly_q;

  // ack_id only matters while the strobe is high.
  assign ack_hit = bus.ack ? (4'b0001 << bus.ack_id) : 4'b0000;

  // Synchroniser chain plus one extra delay flop for edge detection. All of
  // it is cleared by reset so a request held high across reset release is
  // seen as exactly one fresh rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < SYNC_STAGES; j++) begin
        sync_q[j] <= 4'b0000;
      end
      dly_q <= 4'b0000;
    end else begin
      sync_q[0] <= bus.req_in;
      for (int j = 1; j < SYNC_STAGES; j++) begin
        sync_q[j] <= sync_q[j-1];
      end
      dly_q <= sync_s;
    end
  end

  // Edge mode: a rise sets pending and beats a same-cycle ack, and an ack that
  // coincides with the rise also suppresses overflow (the event simply
  // re-pends). A set condition beats ovf_clr.
  // Level mode: pending mirrors the synchronised level except for the single
  // cycle in which that channel is acknowledged; overflow never fires.
  always_comb begin
    pending_nxt = pending_q;
    ovf_nxt     = ovf_q;
    ovf_set     = 4'b0000;
    if (EDGE_MODE) begin
      ovf_set     = rise & pending_q & ~ack_hit;
      pending_nxt = (pending_q & ~ack_hit) | rise;
      ovf_nxt     = (bus.ovf_clr ? 4'b0000 : ovf_q) | ovf_set;
    end else begin
      pending_nxt = sync_s & ~ack_hit;
      ovf_nxt     = 4'b0000;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= 4'b0000;
      ovf_q     <= 4'b0000;
    end else begin
      pending_q <= pending_nxt;
      ovf_q     <= ovf_nxt;
    end
  end

  // Masking only hides a channel from the encoder; capture carries on.
  assign presented   = pending_q & bus.mask;
  assign bus.i0      = presented[0];
  assign bus.i1      = presented[1];
  assign bus.i2      = presented[2];
  assign bus.i3      = presented[3];
  assign bus.irq     = |presented;
  assign bus.pending = pending_q;
  assign bus.ovf     = ovf_q;

endmodule
